wager_ledger: RTL and testbench

// - Parametrised successor to the single-player balance block: per-seat chip ledger for N_SEATS bettors.
// - Accepts per-seat bets (side + amount) while a round is open.
// - Takes the round result from the state machine (endround, pscore, dscore).
// - Settles one seat per clock, then reopens betting. Sits beside the datapath/statemachine pair.

---
 rtl/wager_ledger_if.sv | 35 +++
 rtl/wager_ledger.sv | 133 +++++++++++++
 tb/tb_wager_ledger.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wager_ledger_if.sv
// wager_ledger_if: bet request, round result and balance-read bundle.
// master drives requests; slave is the ledger.
interface wager_ledger_if #(
  parameter int N_SEATS = 4,
  parameter int BAL_W   = 10,
  parameter int BET_W   = 8
);
  localparam int SEAT_W = $clog2(N_SEATS);

  logic              bet_valid;
  logic [SEAT_W-1:0] bet_seat;
  logic [1:0]        bet_side;
  logic [BET_W-1:0]  bet_amt;
  logic              bet_ack;
  logic              endround;
  logic [3:0]        pscore;
  logic [3:0]        dscore;
  logic              busy;
  logic              settle_done;
  logic [SEAT_W-1:0] bal_sel;
  logic [BAL_W-1:0]  bal_out;
  logic [N_SEATS-1:0] broke;

  modport master (
    output bet_valid, bet_seat, bet_side, bet_amt,
    output endround, pscore, dscore, bal_sel,
    input  bet_ack, busy, settle_done, bal_out, broke
  );

  modport slave (
    input  bet_valid, bet_seat, bet_side, bet_amt,
    input  endround, pscore, dscore, bal_sel,
    output bet_ack, busy, settle_done, bal_out, broke
  );
endinterface

// File: rtl/wager_ledger.sv
// wager_ledger: per-seat chip ledger, bets while OPEN, one seat settled per clock.
// Optional macro COMMISSION_EN: dealer-side wins pay s - s/20.
module wager_ledger #(
  parameter int N_SEATS  = 4,
  parameter int BAL_W    = 10,
  parameter int BET_W    = 8,
  parameter int INIT_BAL = 100
) (
  input logic           slow_clock,
  input logic           reset,
  wager_ledger_if.slave bus
);
  localparam int SEAT_W = $clog2(N_SEATS);
  localparam int SUM_W  = BAL_W + 4;
  localparam logic [BAL_W-1:0] BAL_MAX = '1;

  typedef enum logic [1:0] {OPEN, SETTLE, DONE} state_t;
  // outcome reuses the side encoding so a win is side == outcome
  typedef enum logic [1:0] {
    SIDE_NONE   = 2'b00,
    SIDE_PLAYER = 2'b01,
    SIDE_DEALER = 2'b10,
    SIDE_TIE    = 2'b11
  } side_t;

  state_t state, state_nx;
  side_t  outcome;
  logic [SEAT_W-1:0] idx;
  logic [BAL_W-1:0]  bal [N_SEATS];
  side_t             side [N_SEATS];
  logic [BET_W-1:0]  amt [N_SEATS];

  logic             accept, last_seat;
  logic             ack_q, done_q;
  logic [BET_W-1:0] stake, pay_s;
  logic [SUM_W-1:0] cur, s_w, gain, sum;
  logic [BAL_W-1:0] upd;
  logic             live, win, lose;

  assign accept = (state == OPEN) && bus.bet_valid &&
                  ({1'b0, bus.bet_seat} < (SEAT_W+1)'(N_SEATS));
  assign stake = (BAL_W'(bus.bet_amt) < bal[bus.bet_seat]) ?
                 bus.bet_amt : BET_W'(bal[bus.bet_seat]);
  assign last_seat = (idx == SEAT_W'(N_SEATS-1));

`ifdef COMMISSION_EN
  assign pay_s = amt[idx] - amt[idx] / BET_W'(20);
`else
  assign pay_s = amt[idx];
`endif

  always_comb begin
    cur  = SUM_W'(bal[idx]);
    s_w  = SUM_W'(amt[idx]);
    live = (side[idx] != SIDE_NONE) && (amt[idx] != '0);
    win  = live && (side[idx] == outcome);
    lose = live && !win && (outcome != SIDE_TIE);
    gain = s_w;
    unique case (outcome)
      SIDE_DEALER: gain = SUM_W'(pay_s);
      SIDE_TIE:    gain = s_w << 3;
      default:     gain = s_w;
    endcase
    sum = cur + gain;
    unique case (1'b1)
      win:  upd = (sum > SUM_W'(BAL_MAX)) ? BAL_MAX : sum[BAL_W-1:0];
      lose: upd = bal[idx] - BAL_W'(amt[idx]);
      default: upd = bal[idx];
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (reset) state <= OPEN;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      OPEN:    if (bus.endround) state_nx = SETTLE;
      SETTLE:  if (last_seat) state_nx = DONE;
      DONE:    state_nx = OPEN;
      default: state_nx = OPEN;
    endcase
  end

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      idx     <= '0;
      outcome <= SIDE_NONE;
      ack_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < N_SEATS; i++) begin
        bal[i]  <= BAL_W'(INIT_BAL);
        side[i] <= SIDE_NONE;
        amt[i]  <= '0;
      end
    end else begin
      ack_q  <= accept;
      done_q <= (state == DONE);
      if (accept) begin
        side[bus.bet_seat] <= side_t'(bus.bet_side);
        amt[bus.bet_seat]  <= stake;
      end
      unique case (state)
        OPEN: if (bus.endround) begin
          idx <= '0;
          if (bus.pscore > bus.dscore)      outcome <= SIDE_PLAYER;
          else if (bus.dscore > bus.pscore) outcome <= SIDE_DEALER;
          else                              outcome <= SIDE_TIE;
        end
        SETTLE: begin
          bal[idx] <= upd;
          idx      <= idx + SEAT_W'(1);
        end
        DONE: for (int i = 0; i < N_SEATS; i++) begin
          side[i] <= SIDE_NONE;
          amt[i]  <= '0;
        end
        default: ;
      endcase
    end
  end

  assign bus.bet_ack     = ack_q;
  assign bus.settle_done = done_q;
  assign bus.busy        = (state != OPEN);
  assign bus.bal_out     = bal[bus.bal_sel];

  for (genvar i = 0; i < N_SEATS; i++) begin : g_broke
    assign bus.broke[i] = (bal[i] == '0);
  end
endmodule

// File: tb/tb_wager_ledger.sv
// tb_wager_ledger: directed + random bets/rounds against a rule-level ledger model.
// Driver queues expected acks and balance snapshots; a negedge monitor checks them.
module tb_wager_ledger;
  localparam int N     = 4;
  localparam int BAL_W = 10;
  localparam int BET_W = 8;
  localparam int INIT  = 100;
  localparam int MAXB  = 1023;

  logic clk = 1'b0;
  logic rst;
  always #10 clk = ~clk;

  wager_ledger_if #(.N_SEATS(N), .BAL_W(BAL_W), .BET_W(BET_W)) bus ();

  wager_ledger #(
    .N_SEATS(N), .BAL_W(BAL_W), .BET_W(BET_W), .INIT_BAL(INIT)
  ) dut (
    .slow_clock(clk),
    .reset(rst),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;
  int ref_bal [N];
  int ref_side [N];
  int ref_amt [N];
  int ack_q [$];
  logic [N-1:0][BAL_W-1:0] snap_q [$];
  logic snap_req = 1'b0;

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int pay(int s);
`ifdef COMMISSION_EN
    return s - s / 20;
`else
    return s;
`endif
  endfunction

  function automatic void model_bet(int seat, int sd, int a);
    ref_side[seat] = sd;
    ref_amt[seat]  = (a < ref_bal[seat]) ? a : ref_bal[seat];
    ack_q.push_back(seat);
  endfunction

  // 1 player, 2 dealer, 3 tie: a bet wins when its side equals the outcome
  function automatic void model_settle(int p, int d);
    int oc;
    oc = (p > d) ? 1 : (d > p) ? 2 : 3;
    for (int i = 0; i < N; i++) begin
      int s = ref_amt[i];
      if (ref_side[i] != 0 && s != 0) begin
        if (ref_side[i] == oc) begin
          int g = (oc == 1) ? s : (oc == 2) ? pay(s) : 8 * s;
          ref_bal[i] = (ref_bal[i] + g > MAXB) ? MAXB : ref_bal[i] + g;
        end else if (oc != 3) begin
          ref_bal[i] -= s;
        end
      end
      ref_side[i] = 0;
      ref_amt[i]  = 0;
    end
  endfunction

  function automatic void push_snap();
    logic [N-1:0][BAL_W-1:0] v;
    for (int i = 0; i < N; i++) v[i] = BAL_W'(ref_bal[i]);
    snap_q.push_back(v);
  endfunction

  task automatic snap();
    push_snap();
    @(posedge clk);
    snap_req = 1'b1;
    @(posedge clk);
    snap_req = 1'b0;
  endtask

  task automatic bet(int seat, int sd, int a);
    @(negedge clk);
    bus.bet_valid = 1'b1;
    bus.bet_seat  = 2'(seat);
    bus.bet_side  = 2'(sd);
    bus.bet_amt   = 8'(a);
    model_bet(seat, sd, a);
  endtask

  task automatic round(int p, int d, bit wb, int seat, int sd, int a);
    int cyc;
    @(negedge clk);
    bus.endround  = 1'b1;
    bus.pscore    = 4'(p);
    bus.dscore    = 4'(d);
    bus.bet_valid = wb;
    if (wb) begin
      bus.bet_seat = 2'(seat);
      bus.bet_side = 2'(sd);
      bus.bet_amt  = 8'(a);
      model_bet(seat, sd, a);
    end
    model_settle(p, d);
    push_snap();
    @(posedge clk);
    #1;
    check("busy_after_endround", int'(bus.busy), 1);
    @(negedge clk);
    bus.endround  = 1'b0;
    bus.bet_valid = 1'b0;
    cyc = 0;
    while (!bus.settle_done && cyc < 20) begin
      bus.bet_valid = (cyc == 2);
      if (cyc == 2) begin
        bus.bet_seat = 2'($urandom_range(0, N-1));
        bus.bet_side = 2'($urandom_range(0, 3));
        bus.bet_amt  = 8'($urandom_range(0, 255));
      end
      @(negedge clk);
      cyc++;
    end
    bus.bet_valid = 1'b0;
    check("settle_latency", cyc, N + 1);
    check("busy_at_settle_done", int'(bus.busy), 0);
  endtask

  task automatic reset_mid();
    bet(0, 2, 40);
    bet(1, 1, 20);
    @(negedge clk);
    bus.bet_valid = 1'b0;
    bus.endround  = 1'b1;
    bus.pscore    = 4'd9;
    bus.dscore    = 4'd2;
    @(negedge clk);
    bus.endround = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      ref_bal[i] = INIT; ref_side[i] = 0; ref_amt[i] = 0;
    end
    repeat (8) begin
      @(negedge clk);
      check("no_done_after_reset", int'(bus.settle_done), 0);
    end
    check("busy_after_reset", int'(bus.busy), 0);
    snap();
  endtask

  initial begin
    logic [N-1:0][BAL_W-1:0] e;
    bus.bal_sel = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.bet_ack) begin
          check("ack_expected", int'(ack_q.size() > 0), 1);
          if (ack_q.size() > 0) void'(ack_q.pop_front());
        end
        if (bus.settle_done || snap_req) begin
          check("snapshot_expected", int'(snap_q.size() > 0), 1);
          if (snap_q.size() > 0) begin
            e = snap_q.pop_front();
            for (int i = 0; i < N; i++) begin
              bus.bal_sel = 2'(i);
              #1;
              check($sformatf("bal_seat%0d", i), int'(bus.bal_out), int'(e[i]));
              check($sformatf("broke_seat%0d", i), int'(bus.broke[i]),
                    int'(e[i] == '0));
            end
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    bus.bet_valid = 1'b0;
    bus.bet_seat  = '0;
    bus.bet_side  = '0;
    bus.bet_amt   = '0;
    bus.endround  = 1'b0;
    bus.pscore    = '0;
    bus.dscore    = '0;
    for (int i = 0; i < N; i++) begin
      ref_bal[i] = INIT; ref_side[i] = 0; ref_amt[i] = 0;
    end
    repeat (3) @(negedge clk);
    check("reset_bet_ack", int'(bus.bet_ack), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_settle_done", int'(bus.settle_done), 0);
    check("reset_broke", int'(bus.broke), 0);
    rst = 1'b0;
    snap();

    bet(0, 1, 30); bet(1, 2, 50);
    round(7, 3, 0, 0, 0, 0);
    bet(2, 3, 10); bet(3, 1, 20);
    round(6, 6, 0, 0, 0, 0);
    bet(0, 2, 255);
    round(9, 2, 0, 0, 0, 0);
    bet(1, 3, 255);
    round(4, 4, 0, 0, 0, 0);
    bet(1, 3, 255);
    round(5, 5, 0, 0, 0, 0);
    bet(1, 1, 100);
    round(9, 1, 0, 0, 0, 0);
    bet(2, 1, 40); bet(2, 1, 10);
    round(9, 1, 1, 3, 2, 5);
    bet(3, 2, 40);
    round(2, 8, 0, 0, 0, 0);

    for (int r = 0; r < 30; r++) begin
      int nb = $urandom_range(0, 4);
      for (int k = 0; k < nb; k++)
        bet($urandom_range(0, N-1), $urandom_range(0, 3), $urandom_range(0, 255));
      round($urandom_range(0, 15), $urandom_range(0, 15),
            $urandom_range(0, 3) == 0, $urandom_range(0, N-1),
            $urandom_range(0, 3), $urandom_range(0, 255));
    end

    reset_mid();
    repeat (4) @(negedge clk);
    check("acks_outstanding", ack_q.size(), 0);
    check("snapshots_outstanding", snap_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
